// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: single-clock I2C bus condition detector.
// Oversamples raw SCL/SDA through synchronisers and a glitch filter, then
// emits one-cycle START / repeated-START / STOP / SCL-edge pulses, tracks
// bus ownership and flags an SCL-low timeout while the bus is busy.
// Ports:
//   clk, rst          system clock, async active-high reset
//   scl_in, sda_in    raw asynchronous pad inputs
//   scl_f, sda_f      filtered lines
//   scl_rise/scl_fall filtered SCL edge pulses
//   start/rstart/stop bus condition pulses
//   bus_busy          level, high from START until STOP or timeout
//   timeout           pulse when SCL has been low too long while busy
module i2c_bus_monitor #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_f,
    output logic sda_f,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic rstart,
    output logic stop,
    output logic bus_busy,
    output logic timeout
);

    localparam int unsigned FCW = $clog2(FILTER_CYCLES + 1);
    localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_CYCLES - 1);
    localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYCLES - 1);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic [FCW-1:0]         scl_cnt_q, scl_cnt_d;
    logic [FCW-1:0]         sda_cnt_q, sda_cnt_d;
    logic                   scl_f_q, scl_f_d;
    logic                   sda_f_q, sda_f_d;
    logic                   scl_p_q, scl_p_d;
    logic                   sda_p_q, sda_p_d;
    logic                   scl_rise_q, scl_rise_d;
    logic                   scl_fall_q, scl_fall_d;
    logic                   start_q, start_d;
    logic                   rstart_q, rstart_d;
    logic                   stop_q, stop_d;
    logic                   timeout_q, timeout_d;
    logic                   state_q, state_d;
    logic [TCW-1:0]         tcnt_q, tcnt_d;

    logic scl_s;
    logic sda_s;
    logic start_cond;
    logic stop_cond;

    // State registers; line-related flops reset to the idle-bus level (1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_p_q    <= 1'b1;
            sda_p_q    <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            rstart_q   <= 1'b0;
            stop_q     <= 1'b0;
            timeout_q  <= 1'b0;
            state_q    <= ST_IDLE;
            tcnt_q     <= '0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_cnt_q  <= scl_cnt_d;
            sda_cnt_q  <= sda_cnt_d;
            scl_f_q    <= scl_f_d;
            sda_f_q    <= sda_f_d;
            scl_p_q    <= scl_p_d;
            sda_p_q    <= sda_p_d;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            rstart_q   <= rstart_d;
            stop_q     <= stop_d;
            timeout_q  <= timeout_d;
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // Sync chains, glitch filters, condition decode and bus-state FSM.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};

        // Filter: toggle only after FILTER_CYCLES consecutive differing samples.
        scl_cnt_d = '0;
        scl_f_d   = scl_f_q;
        if (scl_s != scl_f_q) begin
            if (scl_cnt_q == FILT_LAST) begin
                scl_f_d = ~scl_f_q;
            end else begin
                scl_cnt_d = scl_cnt_q + FCW'(1);
            end
        end

        sda_cnt_d = '0;
        sda_f_d   = sda_f_q;
        if (sda_s != sda_f_q) begin
            if (sda_cnt_q == FILT_LAST) begin
                sda_f_d = ~sda_f_q;
            end else begin
                sda_cnt_d = sda_cnt_q + FCW'(1);
            end
        end

        scl_p_d    = scl_f_q;
        sda_p_d    = sda_f_q;
        scl_rise_d = ~scl_p_q & scl_f_q;
        scl_fall_d = scl_p_q & ~scl_f_q;

        // Requiring SCL high on both samples suppresses conditions when SCL moves too.
        start_cond = scl_p_q & scl_f_q & sda_p_q & ~sda_f_q;
        stop_cond  = scl_p_q & scl_f_q & ~sda_p_q & sda_f_q;

        state_d   = state_q;
        start_d   = 1'b0;
        rstart_d  = 1'b0;
        stop_d    = 1'b0;
        timeout_d = 1'b0;
        tcnt_d    = '0;

        // START/STOP take priority over timeout expiry.
        if (start_cond) begin
            if (state_q == ST_IDLE) begin
                start_d = 1'b1;
            end else begin
                rstart_d = 1'b1;
            end
            state_d = ST_BUSY;
        end else if (stop_cond) begin
            stop_d  = 1'b1;
            state_d = ST_IDLE;
        end else if (state_q == ST_BUSY && !scl_f_q) begin
            if (tcnt_q == TO_LAST) begin
                timeout_d = 1'b1;
                state_d   = ST_IDLE;
                tcnt_d    = tcnt_q;
            end else begin
                tcnt_d = tcnt_q + TCW'(1);
            end
        end
    end

    assign scl_f    = scl_f_q;
    assign sda_f    = sda_f_q;
    assign scl_rise = scl_rise_q;
    assign scl_fall = scl_fall_q;
    assign start    = start_q;
    assign rstart   = rstart_q;
    assign stop     = stop_q;
    assign bus_busy = state_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for i2c_bus_monitor (SYNC_STAGES=2, FILTER_CYCLES=4,
// TIMEOUT_CYCLES=100). Inputs change on falling clock edges; outputs are
// sampled on falling edges. Pin-to-pulse latency is 7 clocks.
module tb_i2c_bus_monitor;

    logic clk = 1'b0;
    logic rst;
    logic scl_in;
    logic sda_in;
    logic scl_f, sda_f, scl_rise, scl_fall;
    logic start, rstart, stop, bus_busy, timeout;

    int n_checks = 0;
    int n_errors = 0;

    // Pulse tallies, written only by the monitor process.
    int n_rise = 0, n_fall = 0, n_start = 0, n_rstart = 0, n_stop = 0;
    int n_to = 0, n_sdalow = 0, n_multi = 0;
    // Snapshots, written only by the stimulus process.
    int s_rise, s_fall, s_start, s_rstart, s_stop, s_to, s_sdalow;

    i2c_bus_monitor #(
        .SYNC_STAGES   (2),
        .FILTER_CYCLES (4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .scl_in  (scl_in),
        .sda_in  (sda_in),
        .scl_f   (scl_f),
        .sda_f   (sda_f),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start   (start),
        .rstart  (rstart),
        .stop    (stop),
        .bus_busy(bus_busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (scl_rise) n_rise   <= n_rise + 1;
            if (scl_fall) n_fall   <= n_fall + 1;
            if (start)    n_start  <= n_start + 1;
            if (rstart)   n_rstart <= n_rstart + 1;
            if (stop)     n_stop   <= n_stop + 1;
            if (timeout)  n_to     <= n_to + 1;
            if (!sda_f)   n_sdalow <= n_sdalow + 1;
            if ((32'(start) + 32'(rstart) + 32'(stop)) > 1) n_multi <= n_multi + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        s_rise   = n_rise;
        s_fall   = n_fall;
        s_start  = n_start;
        s_rstart = n_rstart;
        s_stop   = n_stop;
        s_to     = n_to;
        s_sdalow = n_sdalow;
    endtask

    initial begin
        rst    = 1'b1;
        scl_in = 1'b1;
        sda_in = 1'b1;
        step(3);
        check_eq("rst_busy", 32'(bus_busy), 0);
        check_eq("rst_scl_f", 32'(scl_f), 1);
        check_eq("rst_sda_f", 32'(sda_f), 1);

        // Idle bus after reset
        rst = 1'b0;
        step(20);
        check_eq("idle_scl_f", 32'(scl_f), 1);
        check_eq("idle_sda_f", 32'(sda_f), 1);
        check_eq("idle_busy", 32'(bus_busy), 0);
        check_eq("idle_pulses", 32'(n_rise + n_fall + n_start + n_rstart + n_stop + n_to), 0);

        // START: SDA falls with SCL high, pulse 7 clocks later
        sda_in = 1'b0;
        step(6);
        check_eq("start_early", 32'(start), 0);
        check_eq("start_busy_early", 32'(bus_busy), 0);
        step(1);
        check_eq("start_pulse", 32'(start), 1);
        check_eq("start_busy", 32'(bus_busy), 1);
        check_eq("start_sda_f", 32'(sda_f), 0);
        check_eq("start_no_rstart", 32'(rstart), 0);
        step(1);
        check_eq("start_width", 32'(start), 0);

        // Nine SCL periods of 20 clocks
        snap();
        for (int i = 0; i < 9; i++) begin
            scl_in = 1'b0;
            step(10);
            scl_in = 1'b1;
            step(10);
        end
        check_eq("clk_rise_cnt", 32'(n_rise - s_rise), 9);
        check_eq("clk_fall_cnt", 32'(n_fall - s_fall), 9);
        check_eq("clk_no_cond", 32'((n_start - s_start) + (n_stop - s_stop) + (n_rstart - s_rstart)), 0);
        check_eq("clk_busy", 32'(bus_busy), 1);

        // Repeated START: raise SDA under SCL low, then fall with SCL high
        scl_in = 1'b0;
        step(10);
        sda_in = 1'b1;
        step(10);
        scl_in = 1'b1;
        step(10);
        snap();
        sda_in = 1'b0;
        step(6);
        check_eq("rstart_early", 32'(rstart), 0);
        step(1);
        check_eq("rstart_pulse", 32'(rstart), 1);
        check_eq("rstart_no_start", 32'(start), 0);
        check_eq("rstart_busy", 32'(bus_busy), 1);
        step(10);
        check_eq("rstart_cnt", 32'(n_rstart - s_rstart), 1);
        check_eq("rstart_start_cnt", 32'(n_start - s_start), 0);

        // STOP: SDA rises with SCL high
        scl_in = 1'b0;
        step(10);
        scl_in = 1'b1;
        step(10);
        sda_in = 1'b1;
        step(6);
        check_eq("stop_early", 32'(stop), 0);
        check_eq("stop_busy_early", 32'(bus_busy), 1);
        step(1);
        check_eq("stop_pulse", 32'(stop), 1);
        check_eq("stop_busy", 32'(bus_busy), 0);
        step(1);
        check_eq("stop_width", 32'(stop), 0);
        step(10);

        // 3-clock SDA glitch is rejected
        snap();
        sda_in = 1'b0;
        step(3);
        sda_in = 1'b1;
        step(15);
        check_eq("glitch3_start", 32'(n_start - s_start), 0);
        check_eq("glitch3_sda_low", 32'(n_sdalow - s_sdalow), 0);
        check_eq("glitch3_sda_f", 32'(sda_f), 1);

        // 4-clock SDA low passes the filter: START then STOP
        sda_in = 1'b0;
        step(4);
        sda_in = 1'b1;
        step(3);
        check_eq("glitch4_start", 32'(start), 1);
        check_eq("glitch4_busy", 32'(bus_busy), 1);
        step(12);
        check_eq("glitch4_stop_cnt", 32'(n_stop - s_stop), 1);
        check_eq("glitch4_busy_end", 32'(bus_busy), 0);

        // Timeout: START, then SCL held low
        sda_in = 1'b0;
        step(10);
        check_eq("to_busy_start", 32'(bus_busy), 1);
        scl_in = 1'b0;
        step(105);
        check_eq("to_early", 32'(timeout), 0);
        check_eq("to_busy_early", 32'(bus_busy), 1);
        step(1);
        check_eq("to_pulse", 32'(timeout), 1);
        check_eq("to_busy", 32'(bus_busy), 0);
        step(1);
        check_eq("to_width", 32'(timeout), 0);
        snap();
        step(150);
        check_eq("to_no_second", 32'(n_to - s_to), 0);
        check_eq("to_busy_held", 32'(bus_busy), 0);
        scl_in = 1'b1;
        step(10);
        sda_in = 1'b1;
        step(10);
        check_eq("to_recover_busy", 32'(bus_busy), 0);

        // Simultaneous SCL/SDA change: only the SCL edge fires
        snap();
        scl_in = 1'b0;
        sda_in = 1'b0;
        step(20);
        check_eq("sim_fall_cnt", 32'(n_fall - s_fall), 1);
        check_eq("sim_fall_no_cond", 32'((n_start - s_start) + (n_stop - s_stop) + (n_rstart - s_rstart)), 0);
        scl_in = 1'b1;
        sda_in = 1'b1;
        step(20);
        check_eq("sim_rise_cnt", 32'(n_rise - s_rise), 1);
        check_eq("sim_rise_no_cond", 32'((n_start - s_start) + (n_stop - s_stop) + (n_rstart - s_rstart)), 0);
        check_eq("sim_busy", 32'(bus_busy), 0);

        // Reset asserted mid-transaction
        sda_in = 1'b0;
        step(10);
        check_eq("rstmid_busy_before", 32'(bus_busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rstmid_busy", 32'(bus_busy), 0);
        check_eq("rstmid_sda_f", 32'(sda_f), 1);
        check_eq("rstmid_scl_f", 32'(scl_f), 1);
        check_eq("rstmid_pulses", 32'(32'(start) + 32'(rstart) + 32'(stop) + 32'(timeout) + 32'(scl_rise) + 32'(scl_fall)), 0);
        sda_in = 1'b1;
        step(2);
        rst = 1'b0;
        step(20);
        check_eq("rstmid_idle_busy", 32'(bus_busy), 0);
        check_eq("one_cond_per_cycle", 32'(n_multi), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_bus_monitor.md
# i2c_bus_monitor

Clocked, parametrised I2C bus condition detector. It replaces the SDA/SCL-clocked start/stop detector with a single-clock design. SCL and SDA are oversampled through synchronisers and a glitch filter. The block then flags START, repeated START, STOP and SCL edges as one-cycle pulses, tracks bus ownership and detects SCL-low timeouts. It sits between the pads and the subordinate's shift/FSM logic, which consumes its pulses and filtered lines.

## Interface

- SYNC_STAGES, 2, synchroniser flops per input line (≥2).
- FILTER_CYCLES, 4, consecutive stable samples required before a filtered line changes (≥1).
- TIMEOUT_CYCLES, 1000, clocks of continuous SCL-low while busy before timeout (≥2).

- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- scl_in  in  1  raw SCL pad input, asynchronous.
- sda_in  in  1  raw SDA pad input, asynchronous.
- scl_f  out  1  filtered SCL.
- sda_f  out  1  filtered SDA.
- scl_rise  out  1  one-cycle pulse on a filtered SCL 0→1 transition.
- scl_fall  out  1  one-cycle pulse on a filtered SCL 1→0 transition.
- start  out  1  one-cycle pulse on a START while the bus is idle.
- rstart  out  1  one-cycle pulse on a START while the bus is busy (repeated START).
- stop  out  1  one-cycle pulse on a STOP.
- bus_busy  out  1  level: high from START until STOP or timeout.
- timeout  out  1  one-cycle pulse when the SCL-low timeout expires.

## Operation

- **Reset values:**
  - Synchroniser flops, scl_f, sda_f and the previous-value registers reset to 1 (idle bus).
  - Filter counters, timeout counter, all pulses and bus_busy reset to 0.
- **Synchroniser:** SYNC_STAGES-deep flop chain per line; its output is scl_s / sda_s.
- **Filter (per line):**
  - Counter width $clog2(FILTER_CYCLES+1).
  - If the synchronised value equals the filtered value, the counter clears.
  - Otherwise the counter increments. When it has counted FILTER_CYCLES consecutive differing cycles, the filtered value toggles and the counter clears.
  - Any sample equal to the filtered value restarts the count, so glitches shorter than FILTER_CYCLES clocks are rejected.
- **Edge/condition detect:**
  - Registers scl_p and sda_p hold the previous filtered values.
  - START condition: scl_p=1, scl_f=1, sda_p=1, sda_f=0.
  - STOP condition: scl_p=1, scl_f=1, sda_p=0, sda_f=1.
  - scl_rise is registered from !scl_p & scl_f; scl_fall from scl_p & !scl_f.
- **Simultaneous SCL and SDA filtered change in one cycle:** no START or STOP is flagged; only the SCL edge pulse fires.
- **Bus state (two states, IDLE and BUSY, equal to bus_busy):**
  - IDLE → BUSY on a START condition, which pulses start.
  - BUSY on a START condition pulses rstart and stays BUSY.
  - BUSY → IDLE on a STOP condition, which pulses stop.
  - A STOP condition in IDLE still pulses stop; state stays IDLE.
  - BUSY → IDLE on timeout expiry, which pulses timeout.
- **Timeout counter:**
  - Counts while bus_busy=1 and scl_f=0. It clears when scl_f=1, when bus_busy=0, or on any START/STOP.
  - It saturates, so there is no wrap.
  - When it reaches TIMEOUT_CYCLES-1 and scl_f is still 0, timeout pulses and bus_busy clears next edge.
  - No further timeout pulse occurs until a new START.
- **Timeout and START/STOP in the same cycle:** START/STOP wins and timeout is suppressed. This case is only reachable when SCL is high, so it cannot normally occur.

## Timing

- Pin change to synchronised output: SYNC_STAGES clocks.
- Synchronised to filtered change: FILTER_CYCLES clocks.
- Filtered change to pulse output: 1 clock.
- Total pin-to-pulse latency: SYNC_STAGES+FILTER_CYCLES+1 clocks; 7 at defaults.
- bus_busy changes on the same edge the start/stop/timeout pulse asserts.
- All pulses are exactly one clock wide. At most one of start/rstart/stop asserts per cycle.
- Minimum resolvable SDA setup/hold around SCL: FILTER_CYCLES+1 clocks. Faster transitions are filtered, not mis-decoded.
- Asserting rst mid-transaction returns the block to IDLE immediately with all pulses low. After deassertion, a held-low SCL or SDA takes the full latency to appear on scl_f/sda_f and produces no START.

## Test plan

- **Reset idle** (SYNC_STAGES=2, FILTER_CYCLES=4): both lines high for 20 clocks → scl_f=sda_f=1, no pulses, bus_busy=0.
- **Clean transaction:** SCL high, SDA 1→0 at cycle 10 → start at cycle 17, bus_busy=1. Then clock 9 SCL periods of 20 clocks → 9 scl_rise and 9 scl_fall pulses. SDA 0→1 with SCL high → stop 7 clocks later, bus_busy=0.
- **Repeated START:** a second SDA fall while SCL is high and the bus is busy → rstart pulse, no start pulse, bus_busy stays 1.
- **Glitch rejection:** 3-clock SDA low glitch while SCL is high → no start, sda_f stays 1. A 4-clock low → start pulses.
- **Timeout** (TIMEOUT_CYCLES=100): START, then SCL held low → timeout pulses exactly 100 clocks after scl_f falls and bus_busy=0. SCL held low longer → no second pulse.
- **Simultaneous/reset:** SCL and SDA fall together → scl_fall only. rst pulsed while busy → bus_busy=0 immediately, all outputs at reset values.
